// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, timing defaults and parity helper
//
// Contents:
//   uart_tx_state_t  transmitter FSM states
//   OSR              receiver oversampling ratio
//   BAUD_PERIOD_CLKS system clocks per bit at the default baud rate
//   parity_bit()     parity over a zero-extended word, also used by uart_receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int CLK_HZ           = 100_000_000;
  localparam int BAUD_RATE        = 115_200;
  localparam int OSR              = 16;
  localparam int BAUD_PERIOD_CLKS = CLK_HZ / BAUD_RATE;

  // Zero-extension does not change the count of ones, so narrower words can
  // be passed in directly. Even parity makes ones(data)+parity even.
  function automatic logic parity_bit(input logic [31:0] data, input logic even);
    return even ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO in front of the transmitter holding register
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write request and word
//   pop, pop_data       read request; pop_data shows the head word
//   count, full, empty  occupancy status
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // A push while full is still accepted when a pop frees a slot the same cycle.
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - LSB-first UART frame serialiser with holding register
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   baud_tick                   one-clk pulse per bit period
//   data_in, data_in_valid      word offered by the host
//   data_in_ready               word accepted on this cycle when valid
//   tx_busy                     frame in progress or word pending
//   RsTx                        serial line, idle high
//
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-word
// uart_tx_fifo ahead of the holding register.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_EVEN = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic              tx_busy,
  output logic              RsTx
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic              LAST_STOP = (STOP_BITS == 2);

  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("uart_transmitter: DATA_W must be 1..32");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_transmitter: FIFO_DEPTH must be a power of 2, >= 2");
  end

  uart_tx_state_t    state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              parity_q;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;

  logic              hold_load;
  logic [DATA_W-1:0] hold_src;
  logic              fifo_pending;
  logic              start_frame;

`ifdef UART_TX_FIFO_EN
  logic [DATA_W-1:0]          fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_in_valid && data_in_ready),
    .push_data (data_in),
    .pop       (hold_load),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign data_in_ready = !fifo_full;
  assign hold_load     = !fifo_empty && !hold_full;
  assign hold_src      = fifo_dout;
  assign fifo_pending  = (fifo_count != '0);
`else
  assign data_in_ready = !hold_full;
  assign hold_load     = data_in_valid && data_in_ready;
  assign hold_src      = data_in;
  assign fifo_pending  = 1'b0;
`endif

  // A new frame starts from IDLE, or directly off the tick that ends the last
  // stop bit so back-to-back words leave no idle period.
  assign start_frame = baud_tick && hold_full &&
                       ((state == IDLE) || ((state == STOP) && (stop_cnt == LAST_STOP)));

  assign tx_busy = (state != IDLE) || hold_full || fifo_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      parity_q  <= 1'b0;
      RsTx      <= 1'b1;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      // Load needs holding empty and start_frame needs it full, so they never collide.
      if (hold_load) begin
        hold_full <= 1'b1;
        hold_data <= hold_src;
      end else if (start_frame) begin
        hold_full <= 1'b0;
      end

      if (start_frame) begin
        state     <= START;
        shift_reg <= hold_data;
        parity_q  <= parity_bit(32'(hold_data), (PARITY_EVEN != 0));
        RsTx      <= 1'b0;
      end else if (baud_tick) begin
        case (state)
          START: begin
            RsTx      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= '0;
            state     <= DATA;
          end
          DATA: begin
            // bit_cnt is the index of the data bit currently on the line.
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= 1'b0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                RsTx  <= parity_q;
              end else begin
                state <= STOP;
                RsTx  <= 1'b1;
              end
            end else begin
              RsTx      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            state    <= STOP;
            RsTx     <= 1'b1;
            stop_cnt <= 1'b0;
          end
          STOP: begin
            if (stop_cnt == LAST_STOP) begin
              state <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;

  localparam int P  = 4;
  localparam int NI = 5;

  int cw    [NI] = '{8, 8, 8, 1, 32};
  int cpen  [NI] = '{0, 1, 1, 1, 1};
  int cpev  [NI] = '{1, 1, 0, 1, 0};
  int cstop [NI] = '{1, 2, 1, 2, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        baud_tick;
  logic [31:0] din  [NI];
  logic        vld  [NI];
  logic        rdy  [NI];
  logic        busy [NI];
  logic        rstx [NI];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int fall_cyc [NI];
  logic prev_tx [NI];

  uart_transmitter #(.DATA_W(8), .PARITY_EN(0), .PARITY_EVEN(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(din[0][7:0]), .data_in_valid(vld[0]),
    .data_in_ready(rdy[0]), .tx_busy(busy[0]), .RsTx(rstx[0]));
  uart_transmitter #(.DATA_W(8), .PARITY_EN(1), .PARITY_EVEN(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(din[1][7:0]), .data_in_valid(vld[1]),
    .data_in_ready(rdy[1]), .tx_busy(busy[1]), .RsTx(rstx[1]));
  uart_transmitter #(.DATA_W(8), .PARITY_EN(1), .PARITY_EVEN(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(din[2][7:0]), .data_in_valid(vld[2]),
    .data_in_ready(rdy[2]), .tx_busy(busy[2]), .RsTx(rstx[2]));
  uart_transmitter #(.DATA_W(1), .PARITY_EN(1), .PARITY_EVEN(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(din[3][0:0]), .data_in_valid(vld[3]),
    .data_in_ready(rdy[3]), .tx_busy(busy[3]), .RsTx(rstx[3]));
  uart_transmitter #(.DATA_W(32), .PARITY_EN(1), .PARITY_EVEN(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .data_in(din[4]), .data_in_valid(vld[4]),
    .data_in_ready(rdy[4]), .tx_busy(busy[4]), .RsTx(rstx[4]));

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : baud_gen
    int cnt;
    cnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (cnt == P - 1);
      cnt = (cnt + 1) % P;
    end
  end

  initial begin : edge_watch
    for (int k = 0; k < NI; k++) begin
      prev_tx[k] = 1'b1;
      fall_cyc[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (prev_tx[k] === 1'b1 && rstx[k] === 1'b0) fall_cyc[k] = cyc;
        prev_tx[k] = rstx[k];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  // Reference model: the frame as a bit list, index 0 = start bit.
  function automatic int frame_len(input int k);
    return 1 + cw[k] + cpen[k] + cstop[k];
  endfunction

  function automatic logic [31:0] mask_word(input int k, input logic [31:0] d);
    logic [63:0] m;
    m = (64'd1 << cw[k]) - 64'd1;
    return d & m[31:0];
  endfunction

  function automatic logic [39:0] frame_bits(input int k, input logic [31:0] d);
    logic [39:0] b;
    int ones, idx, par;
    b = '0;
    ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < cw[k]; i++) begin
      b[1 + i] = d[i];
      ones += int'(d[i]);
    end
    idx = 1 + cw[k];
    if (cpen[k] != 0) begin
      par = ones % 2;
      if (cpev[k] == 0) par = 1 - par;
      b[idx] = (par == 1);
      idx++;
    end
    for (int s = 0; s < cstop[k]; s++) b[idx + s] = 1'b1;
    return b;
  endfunction

  task automatic send(input int k, input logic [31:0] d, output int t_x, output bit ok);
    ok = 1'b0;
    t_x = 0;
    @(negedge clk);
    din[k] = d;
    vld[k] = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (rdy[k] === 1'b1) begin
        ok = 1'b1;
        t_x = cyc;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL send_timeout inst%0d: data_in_ready never high, required 1", k);
      vld[k] = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      vld[k] = 1'b0;
      vectors++;
      if (rdy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_low_holding inst%0d: got %b required 0", k, rdy[k]);
      end
    end
  endtask

  task automatic capture(input int k, output logic [39:0] bits, output int t0, output bit ok);
    ok = 1'b0;
    bits = '0;
    t0 = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (rstx[k] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      t0 = cyc;
      repeat (P / 2) @(negedge clk);
      bits[0] = rstx[k];
      for (int i = 1; i < frame_len(k); i++) begin
        repeat (P) @(negedge clk);
        bits[i] = rstx[k];
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0;
      din[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (rstx[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_rstx inst%0d: got %b required 1", k, rstx[k]);
      end
      vectors++;
      if (rdy[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_ready inst%0d: got %b required 1", k, rdy[k]);
      end
      vectors++;
      if (busy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy inst%0d: got %b required 0", k, busy[k]);
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    logic [39:0] bits;
    int tx, t0, lows;
    bit ok, cok;
    send(0, 32'hA5, tx, ok);
    capture(0, bits, t0, cok);
    vectors++;
    if (!cok) begin
      miscompares++;
      $display("FAIL frame_a5_start: no start bit seen, required one");
    end else begin
      vectors++;
      if (bits !== 40'h34A) begin
        miscompares++;
        $display("FAIL frame_a5_bits: got %h required 34a", bits);
      end
      vectors++;
      if (t0 - tx < 2 || t0 - tx > P + 1) begin
        miscompares++;
        $display("FAIL start_latency: got %0d clk required 2..%0d", t0 - tx, P + 1);
      end
    end
    repeat (P) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_stop: got %b required 0", busy[0]);
    end
    lows = 0;
    repeat (12 * P) begin
      @(negedge clk);
      if (rstx[0] !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL single_frame: got %0d low samples after frame required 0", lows);
    end
  endtask

  task automatic test_parity();
    int          k_list [3] = '{1, 2, 1};
    logic [31:0] d_list [3] = '{32'h07, 32'h07, 32'h00};
    logic        p_list [3] = '{1'b1, 1'b0, 1'b0};
    logic [39:0] bits, expf;
    int tx, t0, k;
    bit ok, cok;
    for (int i = 0; i < 3; i++) begin
      k = k_list[i];
      send(k, d_list[i], tx, ok);
      capture(k, bits, t0, cok);
      repeat (P) @(negedge clk);
      expf = frame_bits(k, d_list[i]);
      vectors++;
      if (!cok || bits[9] !== p_list[i]) begin
        miscompares++;
        $display("FAIL parity_bit inst%0d data %h: got %b required %b", k, d_list[i], bits[9], p_list[i]);
      end
      vectors++;
      if (bits !== expf) begin
        miscompares++;
        $display("FAIL parity_frame inst%0d: got %h required %h", k, bits, expf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] b1, b2, e1, e2;
    int tx1, tx2, t1, t2;
    bit ok1, ok2, c1, c2;
    e1 = frame_bits(0, 32'h3C);
    e2 = frame_bits(0, 32'hC3);
    fork
      begin
        send(0, 32'h3C, tx1, ok1);
        send(0, 32'hC3, tx2, ok2);
      end
      begin
        capture(0, b1, t1, c1);
        capture(0, b2, t2, c2);
      end
    join
    vectors++;
    if (!c1 || b1 !== e1) begin
      miscompares++;
      $display("FAIL b2b_first: got %h required %h", b1, e1);
    end
    vectors++;
    if (!c2 || b2 !== e2) begin
      miscompares++;
      $display("FAIL b2b_second: got %h required %h", b2, e2);
    end
    vectors++;
    if (t2 - t1 != frame_len(0) * P) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d clk between starts required %0d", t2 - t1, frame_len(0) * P);
    end
    repeat (2 * P) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] bits, expf, e96;
    int tx, t0, target, n, lows;
    bit ok, cok;
    send(0, 32'h96, tx, ok);
    send(0, 32'h81, tx, ok);
    target = fall_cyc[0] + 4 * P + 2;
    n = 0;
    while (cyc < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    e96 = frame_bits(0, 32'h96);
    vectors++;
    if (rstx[0] !== e96[4]) begin
      miscompares++;
      $display("FAIL mid_bit3: got %b required %b", rstx[0], e96[4]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (rstx[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_rstx: got %b required 1", rstx[0]);
    end
    vectors++;
    if (rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_ready: got %b required 1", rdy[0]);
    end
    vectors++;
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b required 0", busy[0]);
    end
    lows = 0;
    repeat (20 * P) begin
      @(negedge clk);
      if (rstx[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL abort_dropped_pending: got %0d active cycles required 0", lows);
    end
    send(0, 32'h55, tx, ok);
    capture(0, bits, t0, cok);
    expf = frame_bits(0, 32'h55);
    vectors++;
    if (!cok || bits !== expf) begin
      miscompares++;
      $display("FAIL post_reset_frame: got %h required %h", bits, expf);
    end
    repeat (2 * P) @(negedge clk);
  endtask

  task automatic test_random(input int k, input int nwords);
    logic [31:0] q[$];
    fork
      begin
        logic [31:0] d;
        int tx;
        bit ok;
        for (int i = 0; i < nwords; i++) begin
          d = mask_word(k, $urandom);
          send(k, d, tx, ok);
          if (ok) q.push_back(d);
          repeat ($urandom_range(0, 3 * P)) @(negedge clk);
        end
      end
      begin
        logic [39:0] bits, expf;
        logic [31:0] w;
        int t0;
        bit cok;
        for (int i = 0; i < nwords; i++) begin
          capture(k, bits, t0, cok);
          vectors++;
          if (!cok || q.size() == 0) begin
            miscompares++;
            $display("FAIL random_missing inst%0d word %0d: got no frame required one", k, i);
          end else begin
            w = q.pop_front();
            expf = frame_bits(k, w);
            if (bits !== expf) begin
              miscompares++;
              $display("FAIL random_frame inst%0d word %0d data %h: got %h required %h", k, i, w, bits, expf);
            end
          end
        end
      end
    join
    repeat (2 * P) @(negedge clk);
    vectors++;
    if (busy[k] !== 1'b0 || rstx[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL random_idle inst%0d: got busy=%b line=%b required busy=0 line=1", k, busy[k], rstx[k]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_random(0, 20);
    test_random(1, 20);
    test_random(2, 20);
    test_random(3, 20);
    test_random(4, 10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
